pid_plant_port: RTL and testbench

- Plant-side companion to the time-multiplexed PID controller.
- Consumes the controller's channel address `a`, data strobe `ce` and signed motor power, and drives one sign/magnitude PWM output per channel.
- Counts per-channel quadrature encoder positions and presents `error = setpoint - position` for the currently addressed channel back to the controller.
- Setpoints are written by the CPU-side register interface.

---
 rtl/pid_plant_port.sv | 164 ++++++++++++++++
 tb/tb_pid_plant_port.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_plant_port.sv
// Plant-side port for the time-multiplexed PID loop: quadrature position counters,
// per-channel setpoints, registered error readback and sign/magnitude PWM drivers.
module pid_plant_port #(
    parameter int aw = 1,
    parameter int an = 2**aw,
    parameter int ow = 12,
    parameter int ew = 24
) (
    input  logic            clk_pid,
    input  logic            reset,
    input  logic [aw-1:0]   a,
    input  logic            ce,
    input  logic [ow-1:0]   m_k_in,
    output logic [ew-1:0]   error,
    input  logic            setpoint_wr,
    input  logic [aw-1:0]   setpoint_addr,
    input  logic [ew-1:0]   setpoint_data,
    input  logic [an-1:0]   encoder_a,
    input  logic [an-1:0]   encoder_b,
    output logic [an-1:0]   pwm_out,
    output logic [an-1:0]   dir_out,
    output logic [an-1:0]   glitch
);

    // Last counter value of the PWM period (all ones minus one).
    localparam logic [ow-2:0] CNT_LAST = ~((ow-1)'(1));

    logic [an-1:0] r_a_s1;
    logic [an-1:0] r_a_s2;
    logic [an-1:0] r_b_s1;
    logic [an-1:0] r_b_s2;
    logic [an-1:0] r_a_prev;
    logic [an-1:0] r_b_prev;

    logic [ew-1:0] r_pos [an];
    logic [ew-1:0] r_sp  [an];
    logic [ew-1:0] r_error;
    logic [an-1:0] r_glitch;

    logic [ow-2:0] r_duty_sh  [an];
    logic [ow-2:0] r_duty_act [an];
    logic [an-1:0] r_dir_sh;
    logic [an-1:0] r_dir_act;
    logic [an-1:0] r_dir_out;
    logic [an-1:0] r_pwm;
    logic [ow-2:0] r_cnt;

    logic [an-1:0] w_up;
    logic [an-1:0] w_dn;
    logic [an-1:0] w_bad;
    logic [ow-1:0] w_abs;
    logic [ow-2:0] w_mag;
    logic          w_boundary;

    // Gray-code step decode from previous {A,B} to current {A,B}.
    always_comb begin
        w_up  = '0;
        w_dn  = '0;
        w_bad = '0;
        for (int ch = 0; ch < an; ch++) begin
            w_up[ch] = ({r_a_prev[ch], r_b_prev[ch], r_a_s2[ch], r_b_s2[ch]} == 4'b0001) ||
                       ({r_a_prev[ch], r_b_prev[ch], r_a_s2[ch], r_b_s2[ch]} == 4'b0111) ||
                       ({r_a_prev[ch], r_b_prev[ch], r_a_s2[ch], r_b_s2[ch]} == 4'b1110) ||
                       ({r_a_prev[ch], r_b_prev[ch], r_a_s2[ch], r_b_s2[ch]} == 4'b1000);
            w_dn[ch] = ({r_a_prev[ch], r_b_prev[ch], r_a_s2[ch], r_b_s2[ch]} == 4'b0100) ||
                       ({r_a_prev[ch], r_b_prev[ch], r_a_s2[ch], r_b_s2[ch]} == 4'b1101) ||
                       ({r_a_prev[ch], r_b_prev[ch], r_a_s2[ch], r_b_s2[ch]} == 4'b1011) ||
                       ({r_a_prev[ch], r_b_prev[ch], r_a_s2[ch], r_b_s2[ch]} == 4'b0010);
            w_bad[ch] = (r_a_prev[ch] != r_a_s2[ch]) && (r_b_prev[ch] != r_b_s2[ch]);
        end
    end

    // Magnitude of the most negative input saturates to full duty.
    always_comb begin
        w_abs = m_k_in[ow-1] ? (~m_k_in + 1'b1) : m_k_in;
        w_mag = w_abs[ow-1] ? '1 : w_abs[ow-2:0];
    end

    assign w_boundary = (r_cnt == CNT_LAST);

    always_ff @(posedge clk_pid) begin
        if (reset) begin
            r_a_s1   <= '0;
            r_a_s2   <= '0;
            r_b_s1   <= '0;
            r_b_s2   <= '0;
            r_a_prev <= '0;
            r_b_prev <= '0;
        end else begin
            r_a_s1   <= encoder_a;
            r_a_s2   <= r_a_s1;
            r_b_s1   <= encoder_b;
            r_b_s2   <= r_b_s1;
            r_a_prev <= r_a_s2;
            r_b_prev <= r_b_s2;
        end
    end

    always_ff @(posedge clk_pid) begin
        if (reset) begin
            for (int ch = 0; ch < an; ch++) begin
                r_pos[ch] <= '0;
                r_sp[ch]  <= '0;
            end
            r_glitch <= '0;
            r_error  <= '0;
        end else begin
            for (int ch = 0; ch < an; ch++) begin
                if (w_up[ch]) begin
                    r_pos[ch] <= r_pos[ch] + ew'(1);
                end else if (w_dn[ch]) begin
                    r_pos[ch] <= r_pos[ch] - ew'(1);
                end
                // A glitch seen in the same cycle as the clearing write must survive.
                if (w_bad[ch]) begin
                    r_glitch[ch] <= 1'b1;
                end else if (setpoint_wr && (setpoint_addr == aw'(ch))) begin
                    r_glitch[ch] <= 1'b0;
                end
            end
            if (setpoint_wr) begin
                r_sp[setpoint_addr] <= setpoint_data;
            end
            r_error <= r_sp[a] - r_pos[a];
        end
    end

    always_ff @(posedge clk_pid) begin
        if (reset) begin
            for (int ch = 0; ch < an; ch++) begin
                r_duty_sh[ch]  <= '0;
                r_duty_act[ch] <= '0;
            end
            r_dir_sh  <= '0;
            r_dir_act <= '0;
            r_dir_out <= '0;
            r_pwm     <= '0;
            r_cnt     <= '0;
        end else begin
            if (ce) begin
                r_dir_sh[a]  <= m_k_in[ow-1];
                r_duty_sh[a] <= w_mag;
            end
            r_cnt <= w_boundary ? '0 : r_cnt + 1'b1;
            // Active registers take the shadow values as they stood before any same-cycle ce.
            if (w_boundary) begin
                for (int ch = 0; ch < an; ch++) begin
                    r_duty_act[ch] <= r_duty_sh[ch];
                end
                r_dir_act <= r_dir_sh;
            end
            for (int ch = 0; ch < an; ch++) begin
                r_pwm[ch] <= (r_cnt < r_duty_act[ch]);
            end
            r_dir_out <= r_dir_act;
        end
    end

    assign error   = r_error;
    assign glitch  = r_glitch;
    assign pwm_out = r_pwm;
    assign dir_out = r_dir_out;

endmodule

// File: tb/tb_pid_plant_port.sv
// Scoreboard bench for pid_plant_port: stimulus queues expected values, a monitor
// process compares them against the DUT outputs on falling clock edges.
module tb_pid_plant_port;

    localparam int AW = 1;
    localparam int AN = 2;
    localparam int OW = 12;
    localparam int EW = 24;
    localparam int PERIOD = 2047;

    localparam int K_ERR = 0;
    localparam int K_GLT = 1;
    localparam int K_DIR = 2;
    localparam int K_PWM = 3;
    localparam int K_CNT = 4;

    logic            clk_pid = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   a = '0;
    logic            ce = 1'b0;
    logic [OW-1:0]   m_k_in = '0;
    logic [EW-1:0]   error;
    logic            setpoint_wr = 1'b0;
    logic [AW-1:0]   setpoint_addr = '0;
    logic [EW-1:0]   setpoint_data = '0;
    logic [AN-1:0]   encoder_a = '0;
    logic [AN-1:0]   encoder_b = '0;
    logic [AN-1:0]   pwm_out;
    logic [AN-1:0]   dir_out;
    logic [AN-1:0]   glitch;

    typedef struct {
        int          kind;
        int          ch;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   pending = 0;
    int   tcnt = 0;

    pid_plant_port #(.aw(AW), .an(AN), .ow(OW), .ew(EW)) dut (
        .clk_pid       (clk_pid),
        .reset         (reset),
        .a             (a),
        .ce            (ce),
        .m_k_in        (m_k_in),
        .error         (error),
        .setpoint_wr   (setpoint_wr),
        .setpoint_addr (setpoint_addr),
        .setpoint_data (setpoint_data),
        .encoder_a     (encoder_a),
        .encoder_b     (encoder_b),
        .pwm_out       (pwm_out),
        .dir_out       (dir_out),
        .glitch        (glitch)
    );

    always #5 clk_pid = ~clk_pid;

    // Expected PWM counter phase, used only to place a ce on the period boundary.
    always @(posedge clk_pid) begin
        if (reset) tcnt <= 0;
        else       tcnt <= (tcnt == PERIOD - 1) ? 0 : tcnt + 1;
    end

    function automatic string kname(input int k);
        case (k)
            K_ERR:   return "error";
            K_GLT:   return "glitch";
            K_DIR:   return "dir_out";
            K_PWM:   return "pwm_out";
            default: return "pwm_high_count";
        endcase
    endfunction

    task automatic push(input int kind, input int ch, input logic [31:0] exp);
        chk_t c;
        c.kind = kind;
        c.ch   = ch;
        c.exp  = exp;
        q.push_back(c);
        pending++;
    endtask

    task automatic step();
        @(posedge clk_pid);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (pending != 0 && t < 6000) begin
            @(posedge clk_pid);
            t++;
        end
        if (pending != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d checks still pending, required 0", pending);
            q.delete();
            pending = 0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic sp_write(input logic [AW-1:0] addr, input logic [EW-1:0] data);
        step();
        setpoint_wr   = 1'b1;
        setpoint_addr = addr;
        setpoint_data = data;
        step();
        setpoint_wr   = 1'b0;
    endtask

    task automatic enc_step(input int ch, input logic [1:0] ab);
        step();
        encoder_a[ch] = ab[1];
        encoder_b[ch] = ab[0];
        wait_cycles(3);
    endtask

    task automatic motor(input logic [AW-1:0] ch, input logic [OW-1:0] m);
        step();
        a      = ch;
        ce     = 1'b1;
        m_k_in = m;
        step();
        ce     = 1'b0;
    endtask

    // Monitor: one queued expectation per falling edge; count checks span a full period.
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk_pid);
            if (q.size() != 0) begin
                c = q.pop_front();
                act = '0;
                case (c.kind)
                    K_ERR: act = {8'h00, error};
                    K_GLT: act = {30'h0, glitch};
                    K_DIR: act = {30'h0, dir_out};
                    K_PWM: act = {30'h0, pwm_out};
                    default: begin
                        act = 32'(pwm_out[c.ch]);
                        for (int i = 1; i < PERIOD; i++) begin
                            @(negedge clk_pid);
                            act = act + 32'(pwm_out[c.ch]);
                        end
                    end
                endcase
                n_checks++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s ch%0d: got %0d (0x%0h), required %0d (0x%0h)",
                             kname(c.kind), c.ch, act, act, c.exp, c.exp);
                end
                pending--;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds everything at zero while the encoder pins toggle randomly.
        push(K_PWM, 0, 32'd0);
        push(K_DIR, 0, 32'd0);
        push(K_ERR, 0, 32'd0);
        push(K_GLT, 0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            encoder_a = AN'($urandom_range(0, 3));
            encoder_b = AN'($urandom_range(0, 3));
        end
        drain();
        step();
        encoder_a = '0;
        encoder_b = '0;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(10);
        push(K_ERR, 0, 32'd0);
        push(K_GLT, 0, 32'd0);
        drain();
        step();
        a = 1'b1;
        wait_cycles(2);
        push(K_ERR, 1, 32'd0);
        drain();

        // Setpoint write: error follows one edge after the write edge.
        step();
        a = 1'b0;
        wait_cycles(2);
        sp_write(1'b0, 24'd1000);
        push(K_ERR, 0, 32'd0);
        push(K_ERR, 0, 32'd1000);
        drain();
        step();
        a = 1'b1;
        push(K_ERR, 0, 32'd1000);
        push(K_ERR, 1, 32'd0);
        drain();

        // Four forward then four reverse quadrature steps on ch0.
        step();
        a = 1'b0;
        enc_step(0, 2'b01);
        enc_step(0, 2'b11);
        enc_step(0, 2'b10);
        enc_step(0, 2'b00);
        wait_cycles(2);
        push(K_ERR, 0, 32'd996);
        push(K_GLT, 0, 32'd0);
        drain();
        enc_step(0, 2'b10);
        enc_step(0, 2'b11);
        enc_step(0, 2'b01);
        enc_step(0, 2'b00);
        wait_cycles(2);
        push(K_ERR, 0, 32'd1000);
        push(K_GLT, 0, 32'd0);
        drain();

        // Ch1 double transition: position holds, sticky glitch until a ch1 write.
        step();
        a = 1'b1;
        enc_step(1, 2'b11);
        wait_cycles(3);
        push(K_ERR, 1, 32'd0);
        push(K_GLT, 1, 32'b10);
        drain();
        wait_cycles(10);
        push(K_GLT, 1, 32'b10);
        drain();
        sp_write(1'b0, 24'd1000);
        wait_cycles(2);
        push(K_GLT, 1, 32'b10);
        drain();
        sp_write(1'b1, 24'd5);
        push(K_GLT, 1, 32'b00);
        push(K_ERR, 1, 32'd5);
        drain();

        // PWM: -512 on ch1.
        motor(1'b1, 12'hE00);
        wait_cycles(2100);
        push(K_DIR, 1, 32'b10);
        push(K_CNT, 1, 32'd512);
        push(K_CNT, 0, 32'd0);
        drain();

        // Most negative input saturates to constantly high.
        motor(1'b1, 12'h800);
        wait_cycles(2100);
        push(K_DIR, 1, 32'b10);
        push(K_CNT, 1, 32'd2047);
        drain();

        // Zero power: constantly low, direction positive.
        motor(1'b1, 12'h000);
        wait_cycles(2100);
        push(K_DIR, 1, 32'b00);
        push(K_CNT, 1, 32'd0);
        drain();

        // Positive power on ch0.
        motor(1'b0, 12'd300);
        wait_cycles(2100);
        push(K_DIR, 0, 32'b00);
        push(K_CNT, 0, 32'd300);
        drain();

        // Back-to-back ce: the later value replaces the earlier one.
        step();
        a      = 1'b1;
        ce     = 1'b1;
        m_k_in = 12'hF38;
        step();
        m_k_in = 12'd700;
        step();
        ce = 1'b0;
        wait_cycles(2100);
        push(K_DIR, 1, 32'b00);
        push(K_CNT, 1, 32'd700);
        drain();

        // ce on the boundary cycle: the old duty lasts one more full period.
        begin
            int t;
            t = 0;
            step();
            while (tcnt != PERIOD - 1 && t < 2200) begin
                step();
                t++;
            end
            if (tcnt != PERIOD - 1) begin
                n_checks++;
                n_fail++;
                $display("FAIL boundary_align: phase %0d, required %0d", tcnt, PERIOD - 1);
            end
        end
        a      = 1'b1;
        ce     = 1'b1;
        m_k_in = 12'd100;
        step();
        ce = 1'b0;
        push(K_CNT, 1, 32'd700);
        drain();
        wait_cycles(2100);
        push(K_CNT, 1, 32'd100);
        drain();

        // Error wraps rather than saturating.
        step();
        a = 1'b0;
        sp_write(1'b0, 24'h800000);
        enc_step(0, 2'b01);
        wait_cycles(3);
        push(K_ERR, 0, 32'h007FFFFF);
        push(K_GLT, 0, 32'b00);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
